simon_pkt_serialiser: RTL and testbench

- Downstream consumer of the SIMON output packetiser.
- Takes each (2+N/2)-byte result packet offered on the packetiser's doneOUT/readOUT handshake and buffers it in a small packet FIFO.
- Emits the packet as a byte stream with valid/ready flow control, toward the UART/host interface.
- Decouples core completion from the slower byte-wide output link.

---
 rtl/simon_pkt_serialiser.sv | 153 +++++++++++++++
 tb/tb_simon_pkt_serialiser.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_pkt_serialiser.sv
// simon_pkt_serialiser: buffers SIMON result packets and streams them out byte by byte
// Ports: clk/R (sync active-high reset); doneOUT/out/readOUT capture packets from the
// packetiser; byte_out/byte_valid/byte_ready/byte_last form the output byte stream;
// pkt_level counts buffered packets including the one being sent.
// Optional: define SIMON_SER_CHECKSUM_EN to append an XOR checksum byte to every packet.
module simon_pkt_serialiser #(
  parameter int N = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     R,
  input  logic                     doneOUT,
  input  logic [(2+N/2)*8-1:0]     out,
  output logic                     readOUT,
  output logic [7:0]               byte_out,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic                     byte_last,
  output logic [$clog2(DEPTH):0]   pkt_level
);
  localparam int P = 2 + N / 2;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int KW = $clog2(P);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
`ifdef SIMON_SER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CHK} state_t;
`else
  typedef enum logic {IDLE, SEND} state_t;
`endif
  logic [P*8-1:0] buf_q [DEPTH];
  logic [P*8-1:0] sreg_q, sreg_d;
  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]  level_q, level_d;
  logic           readout_q, readout_d;
  logic [7:0]     byte_q, byte_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;
`ifdef SIMON_SER_CHECKSUM_EN
  logic [7:0]     chk_q, chk_d;
`endif
  logic           cap, acc, pop;

  always_comb begin
    // capture uses the start-of-cycle level, so a same-cycle pop never frees a slot early
    cap = doneOUT && !readout_q && (level_q < FULL);
    acc = valid_q && byte_ready;
    pop = 1'b0;
    state_d = state_q;
    sreg_d = sreg_q;
    k_d = k_q;
    byte_d = byte_q;
    valid_d = valid_q;
    last_d = last_q;
`ifdef SIMON_SER_CHECKSUM_EN
    chk_d = chk_q;
`endif
    case (state_q)
      IDLE: if (level_q != '0) begin
        sreg_d = buf_q[rd_q];
        byte_d = buf_q[rd_q][(P-1)*8 +: 8];
        k_d = KW'(P - 1);
        valid_d = 1'b1;
        last_d = 1'b0;
        state_d = SEND;
`ifdef SIMON_SER_CHECKSUM_EN
        chk_d = '0;
`endif
      end
      SEND: if (acc) begin
`ifdef SIMON_SER_CHECKSUM_EN
        chk_d = chk_q ^ byte_q;
`endif
        if (k_q != '0) begin
          k_d = k_q - KW'(1);
          sreg_d = sreg_q << 8;
          byte_d = sreg_q[(P-2)*8 +: 8];
`ifndef SIMON_SER_CHECKSUM_EN
          last_d = (k_q == KW'(1));
`endif
        end else begin
`ifdef SIMON_SER_CHECKSUM_EN
          byte_d = chk_q ^ byte_q;
          last_d = 1'b1;
          state_d = CHK;
`else
          pop = 1'b1;
          byte_d = '0;
          valid_d = 1'b0;
          last_d = 1'b0;
          state_d = IDLE;
`endif
        end
      end
`ifdef SIMON_SER_CHECKSUM_EN
      CHK: if (acc) begin
        pop = 1'b1;
        byte_d = '0;
        valid_d = 1'b0;
        last_d = 1'b0;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    readout_d = cap;
    wr_d = cap ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    level_d = level_q + LW'(cap) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= IDLE;
      sreg_q <= '0;
      k_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      readout_q <= 1'b0;
      byte_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
`ifdef SIMON_SER_CHECKSUM_EN
      chk_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q <= sreg_d;
      k_q <= k_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
      readout_q <= readout_d;
      byte_q <= byte_d;
      valid_q <= valid_d;
      last_q <= last_d;
`ifdef SIMON_SER_CHECKSUM_EN
      chk_q <= chk_d;
`endif
    end
  end

  always_ff @(posedge clk) if (cap) buf_q[wr_q] <= out;

  assign readOUT = readout_q;
  assign byte_out = byte_q;
  assign byte_valid = valid_q;
  assign byte_last = last_q;
  assign pkt_level = level_q;
endmodule

// File: tb/tb_simon_pkt_serialiser.sv
// tb_simon_pkt_serialiser: stream-order scoreboard plus directed timing checks for the serialiser
module tb_simon_pkt_serialiser;
  localparam int N = 16;
  localparam int DEPTH = 2;
  localparam int P = 2 + N / 2;
  localparam int LW = $clog2(DEPTH) + 1;
`ifdef SIMON_SER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int NB = P + int'(CK);

  logic clk = 1'b0;
  logic R = 1'b1;
  logic doneOUT = 1'b0;
  logic [P*8-1:0] out = '0;
  logic readOUT;
  logic [7:0] byte_out;
  logic byte_valid;
  logic byte_ready = 1'b0;
  logic byte_last;
  logic [LW-1:0] pkt_level;

  simon_pkt_serialiser #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .R(R), .doneOUT(doneOUT), .out(out), .readOUT(readOUT),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_last(byte_last), .pkt_level(pkt_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = 0;
  int naccepted = 0;
  bit pop_seen = 0;
  logic [P*8-1:0] pend [$];
  logic [7:0] exp_b [$];
  logic exp_l [$];

  task automatic chk(input string tag, input logic [31:0] a, input logic [31:0] e);
    checks++;
    assert (a === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, a, e);
    end
  endtask

  function automatic logic [P*8-1:0] mk(input logic [7:0] info, input logic [7:0] cnt);
    logic [P*8-1:0] p;
    p = {$urandom, $urandom, $urandom};
    p[P*8-1 -: 8] = info;
    p[P*8-9 -: 8] = cnt;
    return p;
  endfunction

  task automatic drive_up();
    if (!doneOUT && pend.size() != 0) begin
      out = pend.pop_front();
      doneOUT = 1'b1;
    end
  endtask

  // the expected stream is every offered packet, most-significant byte first, in offer order
  task automatic offer(input logic [P*8-1:0] p);
    logic [7:0] x;
    x = '0;
    for (int i = P - 1; i >= 0; i--) begin
      exp_b.push_back(p[i*8 +: 8]);
      exp_l.push_back(i == 0 && !CK);
      x ^= p[i*8 +: 8];
    end
    if (CK) begin
      exp_b.push_back(x);
      exp_l.push_back(1'b1);
    end
    pend.push_back(p);
    drive_up();
  endtask

  task automatic cycle();
    logic pv, pr, pl, prd, hs, pR;
    logic [7:0] pb;
    pop_seen = 0;
    if (byte_valid && byte_ready && !R) begin
      chk("byte_expected", 32'(exp_b.size() != 0), 1);
      if (exp_b.size() != 0) begin
        chk("byte_val", 32'(byte_out), 32'(exp_b.pop_front()));
        chk("byte_last", 32'(byte_last), 32'(exp_l.pop_front()));
      end
      pop_seen = byte_last;
      naccepted++;
    end
    pv = byte_valid; pr = byte_ready; pb = byte_out; pl = byte_last;
    prd = readOUT; hs = doneOUT && readOUT; pR = R;
    @(posedge clk);
    #1;
    cyc++;
    if (!pR && !R) begin
      if (pv && !pr) begin
        chk("hold_valid", 32'(byte_valid), 1);
        chk("hold_byte", 32'(byte_out), 32'(pb));
        chk("hold_last", 32'(byte_last), 32'(pl));
      end
      if (prd) chk("rd_pulse", 32'(readOUT), 0);
      chk("lvl_range", 32'(pkt_level <= LW'(DEPTH)), 1);
    end
    if (hs) doneOUT = 1'b0;
    drive_up();
    if (mode == 1) byte_ready = (cyc % 3 == 0);
    else if (mode == 2) byte_ready = ($urandom_range(3) != 0);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((exp_b.size() != 0 || pend.size() != 0 || doneOUT) && n < bound) begin
      cycle();
      n++;
    end
    chk("drain_left", 32'(exp_b.size()), 0);
    chk("drain_lvl", 32'(pkt_level), 0);
  endtask

  initial begin
    logic [P*8-1:0] p0;
    int n;
    // reset
    R = 1'b1;
    cycle();
    cycle();
    R = 1'b0;
    chk("rst_rd", 32'(readOUT), 0);
    chk("rst_valid", 32'(byte_valid), 0);
    chk("rst_byte", 32'(byte_out), 0);
    chk("rst_last", 32'(byte_last), 0);
    chk("rst_lvl", 32'(pkt_level), 0);
    // single packet, sink always ready
    byte_ready = 1'b1;
    offer(80'h90_00_0123_4567_89AB_CDEF);
    cycle();
    chk("t1_rd_hi", 32'(readOUT), 1);
    chk("t1_lvl1", 32'(pkt_level), 1);
    chk("t1_v0", 32'(byte_valid), 0);
    cycle();
    chk("t1_rd_lo", 32'(readOUT), 0);
    chk("t1_v1", 32'(byte_valid), 1);
    chk("t1_first", 32'(byte_out), 32'h90);
    for (int i = 0; i < NB - 1; i++) begin
      cycle();
      chk("t1_contig", 32'(byte_valid), 1);
    end
    cycle();
    chk("t1_done_v", 32'(byte_valid), 0);
    chk("t1_done_lvl", 32'(pkt_level), 0);
    chk("t1_sb", 32'(exp_b.size()), 0);
    // back-pressure pattern 1,0,0
    mode = 1;
    offer(mk(8'h90, 8'h01));
    offer(mk(8'h91, 8'h02));
    drain(200);
    // buffer full with the sink stalled
    mode = 0;
    byte_ready = 1'b0;
    p0 = mk(8'hA0, 8'h00);
    offer(p0);
    offer(mk(8'hA1, 8'h01));
    offer(mk(8'hA2, 8'h02));
    for (int i = 0; i < 8; i++) cycle();
    chk("t3_lvl2", 32'(pkt_level), 2);
    chk("t3_rd_lo", 32'(readOUT), 0);
    chk("t3_pending", 32'(doneOUT), 1);
    chk("t3_head", 32'(byte_out), 32'(p0[P*8-1 -: 8]));
    byte_ready = 1'b1;
    n = 0;
    while (!pop_seen && n < 40) begin
      cycle();
      n++;
    end
    chk("t3_popped", 32'(pop_seen), 1);
    chk("t3_pop_rd", 32'(readOUT), 0);
    chk("t3_pop_lvl", 32'(pkt_level), 1);
    cycle();
    chk("t3_cap_rd", 32'(readOUT), 1);
    chk("t3_cap_lvl", 32'(pkt_level), 2);
    drain(200);
    // capture and pop on the same edge
    offer(mk(8'hB0, 8'h00));
    n = 0;
    while (!(byte_valid && byte_last) && n < 40) begin
      cycle();
      n++;
    end
    chk("t4_at_last", 32'(byte_valid && byte_last), 1);
    chk("t4_lvl_pre", 32'(pkt_level), 1);
    offer(mk(8'hB1, 8'h01));
    cycle();
    chk("t4_lvl_same", 32'(pkt_level), 1);
    chk("t4_rd", 32'(readOUT), 1);
    chk("t4_idle", 32'(byte_valid), 0);
    cycle();
    chk("t4_restart", 32'(byte_valid), 1);
    chk("t4_head", 32'(byte_out), 32'hB1);
    drain(100);
    // reset after four bytes
    offer(mk(8'hC0, 8'h00));
    n = naccepted;
    while (naccepted - n < 4 && cyc < 90000) cycle();
    chk("t5_mid", 32'(byte_valid), 1);
    R = 1'b1;
    byte_ready = 1'b0;
    doneOUT = 1'b0;
    pend.delete();
    exp_b.delete();
    exp_l.delete();
    cycle();
    R = 1'b0;
    chk("t5_v", 32'(byte_valid), 0);
    chk("t5_rd", 32'(readOUT), 0);
    chk("t5_lvl", 32'(pkt_level), 0);
    byte_ready = 1'b1;
    offer(mk(8'hC1, 8'h07));
    cycle();
    cycle();
    chk("t5_fresh", 32'(byte_out), 32'hC1);
    drain(100);
`ifdef SIMON_SER_CHECKSUM_EN
    offer(80'h10_05_0000_0000_0000_00FF);
    n = 0;
    while (!(byte_valid && byte_last) && n < 40) begin
      cycle();
      n++;
    end
    chk("ck_byte", 32'(byte_out), 32'hEA);
    drain(100);
`endif
    // randomized traffic
    mode = 2;
    for (int i = 0; i < 24; i++) begin
      offer(mk(8'($urandom), 8'(i)));
      for (int j = 0; j < int'($urandom_range(6)); j++) cycle();
    end
    drain(3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
